// File: rtl/flex_updown_counter.sv
// Up/down counter over the range 1..R with optional saturation.
// The flags are computed from the next count and registered, so each flag lines up with the count_out value it describes.
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 4,
  parameter bit SATURATE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    terminal_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_roll;
  logic                    r_term;
  logic                    r_wrap;

  logic [NUM_CNT_BITS-1:0] w_next;
  logic                    w_wrap;
  logic                    w_r_zero;
  logic                    w_ge_r;
  logic                    w_gt_r;
  logic                    w_le_one;
  logic                    w_roll;
  logic                    w_term;

  assign w_r_zero = (rollover_val == '0);
  assign w_ge_r   = (r_count >= rollover_val);
  assign w_gt_r   = (r_count >  rollover_val);
  assign w_le_one = (r_count <= ONE);

  // A count left outside 1..R by a load or an R change is pulled back into range on the next enabled edge.
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (clear) begin
      w_next = '0;
    end else if (load) begin
      w_next = load_val;
    end else if (count_enable && !w_r_zero) begin
      if (count_up) begin
        if (!w_ge_r) begin
          w_next = r_count + ONE;
        end else if (SATURATE) begin
          w_next = rollover_val;
        end else begin
          w_next = ONE;
          w_wrap = 1'b1;
        end
      end else begin
        if (!w_le_one && !w_gt_r) begin
          w_next = r_count - ONE;
        end else if (SATURATE) begin
          w_next = w_gt_r ? rollover_val : ONE;
        end else begin
          w_next = rollover_val;
          w_wrap = 1'b1;
        end
      end
    end
  end

  // A zero next count, as produced by clear, can never raise either flag while R is nonzero.
  assign w_roll = !w_r_zero && (w_next == rollover_val);
  assign w_term = !w_r_zero && (w_next == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_roll  <= 1'b0;
      r_term  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_roll  <= w_roll;
      r_term  <= w_term;
      r_wrap  <= w_wrap;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_roll;
  assign terminal_flag = r_term;
  assign wrap_pulse    = r_wrap;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Bench for flex_updown_counter: wrap, saturate and 8-bit instances, table vectors, corner sequences, random vs model.
module tb_flex_updown_counter;

  logic clk = 1'b0;
  logic rst, clear, load, en, up;
  logic [3:0] lv4, rv4;
  logic [7:0] lv8, rv8;
  logic [3:0] cw, cs;
  logic [7:0] c8;
  logic rw, tw, ww, rs, ts, ws, r8, t8, w8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flex_updown_counter #(.NUM_CNT_BITS(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(en), .count_up(up), .load(load),
    .load_val(lv4), .rollover_val(rv4), .count_out(cw), .rollover_flag(rw),
    .terminal_flag(tw), .wrap_pulse(ww));

  flex_updown_counter #(.NUM_CNT_BITS(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(en), .count_up(up), .load(load),
    .load_val(lv4), .rollover_val(rv4), .count_out(cs), .rollover_flag(rs),
    .terminal_flag(ts), .wrap_pulse(ws));

  flex_updown_counter #(.NUM_CNT_BITS(8), .SATURATE(1'b0)) dut_8 (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(en), .count_up(up), .load(load),
    .load_val(lv8), .rollover_val(rv8), .count_out(c8), .rollover_flag(r8),
    .terminal_flag(t8), .wrap_pulse(w8));

  typedef struct {
    bit clr, ld, en, up;
    logic [3:0] lv, rv, cnt;
    bit roll, term, wrap;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int c, input int r, input int t, input int w,
                         input int ec, input int er, input int et, input int ew);
    chk({nm, ".count"}, c, ec);
    chk({nm, ".roll"}, r, er);
    chk({nm, ".term"}, t, et);
    chk({nm, ".wrap"}, w, ew);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit l, input bit e, input bit u);
    clear = c; load = l; en = e; up = u;
  endtask

  function automatic vec_t mk(bit c, bit l, bit e, bit u, int lv, int rv, int cnt, bit ro, bit te, bit wr);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.up = u;
    v.lv = 4'(lv); v.rv = 4'(rv); v.cnt = 4'(cnt);
    v.roll = ro; v.term = te; v.wrap = wr;
    return v;
  endfunction

  // Reference behaviour: the count lives in 1..R; leaving that range either wraps to the opposite end or clamps.
  function automatic void model(input int c, input int rr, input bit clr, input bit ld, input int lv,
                                input bit e, input bit u, input bit sat,
                                output int n, output int ro, output int te, output int wr);
    wr = 0;
    if (clr) n = 0;
    else if (ld) n = lv;
    else if (!e || rr == 0) n = c;
    else if (u) begin
      if (c < rr) n = c + 1;
      else if (sat) n = rr;
      else begin n = 1; wr = 1; end
    end else begin
      if (c > 1 && c <= rr) n = c - 1;
      else if (sat) n = (c > rr) ? rr : 1;
      else begin n = rr; wr = 1; end
    end
    ro = (rr != 0 && n == rr) ? 1 : 0;
    te = (rr != 0 && n == 1) ? 1 : 0;
  endfunction

  int mw, ms, m8, n, ro, te, wr;
  int sat_up[6]  = '{1, 2, 3, 3, 3, 3};
  int sat_dn[4]  = '{2, 1, 1, 1};

  initial begin
    rst = 1'b1; clear = 0; load = 0; en = 0; up = 0;
    lv4 = 0; rv4 = 0; lv8 = 0; rv8 = 0;
    #1;
    chk_out("reset_w", cw, rw, tw, ww, 0, 0, 0, 0);
    chk_out("reset_8", c8, r8, t8, w8, 0, 0, 0, 0);
    #12 rst = 1'b0;

    // Up wrap at R=5, then load 3 and count down through a wrap at R=4.
    for (int i = 0; i < 7; i++)
      tbl[i] = mk(0, 0, 1, 1, 0, 5, (i < 5) ? i + 1 : i - 4, i == 4, i == 0 || i == 5, i == 5);
    tbl[7]  = mk(0, 1, 1, 1, 3, 4, 3, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 4, 2, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 4, 1, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 4, 4, 1, 0, 1);
    tbl[11] = mk(0, 0, 1, 0, 0, 4, 3, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 4, 2, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 4, 2, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].up);
      lv4 = tbl[i].lv; rv4 = tbl[i].rv;
      step();
      chk_out($sformatf("tbl%0d", i), cw, rw, tw, ww,
              tbl[i].cnt, tbl[i].roll, tbl[i].term, tbl[i].wrap);
    end

    // Saturation at R=3.
    rst = 1'b1; #2 rst = 1'b0;
    rv4 = 3; drive(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("sat_up%0d", i), cs, rs, ts, ws, sat_up[i], sat_up[i] == 3, sat_up[i] == 1, 0);
    end
    up = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("sat_dn%0d", i), cs, rs, ts, ws, sat_dn[i], 0, sat_dn[i] == 1, 0);
    end

    // Clear beats load, and load beats enable.
    rv4 = 9; lv4 = 7; drive(1, 1, 1, 1);
    step();
    chk_out("prio_clr", cw, rw, tw, ww, 0, 0, 0, 0);
    clear = 0;
    step();
    chk_out("prio_ld", cw, rw, tw, ww, 7, 0, 0, 0);

    // Asynchronous reset while the count sits at R.
    rv4 = 4; lv4 = 4; drive(0, 1, 0, 1);
    step();
    chk_out("pre_rst", cw, rw, tw, ww, 4, 1, 0, 0);
    load = 0; en = 1;
    #2 rst = 1'b1;
    #1 chk_out("mid_rst", cw, rw, tw, ww, 0, 0, 0, 0);
    #2 rst = 1'b0;
    step();
    chk_out("post_rst", cw, rw, tw, ww, 1, 0, 1, 0);

    // R == 0: enable does nothing, load still works.
    rst = 1'b1; #2 rst = 1'b0;
    rv4 = 0; drive(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("r0_%0d", i), cw, rw, tw, ww, 0, 0, 0, 0);
    end
    lv4 = 5; load = 1;
    step();
    load = 0;
    step();
    chk_out("r0_ld", cw, rw, tw, ww, 5, 0, 0, 0);

    // 8-bit wrap from 255.
    rv8 = 255; lv8 = 254; drive(0, 1, 1, 1);
    step();
    load = 0;
    step();
    chk_out("w8_255", c8, r8, t8, w8, 255, 1, 0, 0);
    step();
    chk_out("w8_1", c8, r8, t8, w8, 1, 0, 1, 1);

    // Random stimulus against the model for all three instances.
    drive(0, 0, 0, 0);
    rst = 1'b1; #2 rst = 1'b0;
    mw = 0; ms = 0; m8 = 0;
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = $urandom_range(0, 1);
      lv4   = 4'($urandom_range(0, 15));
      lv8   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) rv4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) rv8 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                                                    : 8'($urandom_range(0, 7));
      model(mw, rv4, clear, load, lv4, en, up, 0, n, ro, te, wr);
      step();
      chk_out($sformatf("rnd_w%0d", i), cw, rw, tw, ww, n, ro, te, wr);
      mw = n;
      model(ms, rv4, clear, load, lv4, en, up, 1, n, ro, te, wr);
      chk_out($sformatf("rnd_s%0d", i), cs, rs, ts, ws, n, ro, te, wr);
      ms = n;
      model(m8, rv8, clear, load, lv8, en, up, 0, n, ro, te, wr);
      chk_out($sformatf("rnd_8_%0d", i), c8, r8, t8, w8, n, ro, te, wr);
      m8 = n;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
